// File: rtl/pulse_filter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pulse_filter_pkg
//  Purpose  : Shared definitions for the pulse_filter_array block.
//             - per-channel mode word layout (SHOW, ONDETECT bit positions)
//             - run-counter width helper
//             - parameter-legality check macro
//  Revision : 1.0  initial release
// ============================================================================

package pulse_filter_pkg;

    // Per-channel pulse-control mode word. Bit SHOW selects showcancelled
    // (1) or noshowcancelled (0). Bit ONDETECT selects error-on-detect (1)
    // or error-on-event (0).
    localparam int SHOW     = 0;
    localparam int ONDETECT = 1;

    typedef logic [1:0] mode_t;

    // The run counter saturates at ERROR_LIM, so it needs to hold the
    // values 0..ERROR_LIM inclusive.
    function automatic int cnt_w(input int error_lim);
        return $clog2(error_lim + 1);
    endfunction

endpackage

// Elaboration-time legality check. Every classified run must still be
// entirely inside the delay line when its terminating edge arrives, which
// is what ties ERROR_LIM to DELAY.
`ifndef PULSE_FILTER_CHECK_PARAMS
`define PULSE_FILTER_CHECK_PARAMS(D, R, E) \
    if (!(((D) >= 1) && ((R) >= 1) && ((R) <= (E)) && ((E) <= (D)))) begin : g_param_check \
        $error("pulse_filter: need DELAY>=1, REJECT_LIM>=1, REJECT_LIM<=ERROR_LIM<=DELAY"); \
    end
`endif

`default_nettype wire

// File: rtl/pulse_filter_array_if.sv
`default_nettype none
// ============================================================================
//  Module   : pulse_filter_array_if
//  Purpose  : Bundles the per-channel data, configuration and status
//             vectors of pulse_filter_array.
//  Ports    : in, cfg_show, cfg_ondetect, err_clr  (driven by master)
//             out, err, err_seen                   (driven by slave)
//  Revision : 1.0  initial release
// ============================================================================

interface pulse_filter_array_if #(
    parameter int CHANNELS = 4
);
    logic [CHANNELS-1:0] in;
    logic [CHANNELS-1:0] cfg_show;
    logic [CHANNELS-1:0] cfg_ondetect;
    logic [CHANNELS-1:0] err_clr;
    logic [CHANNELS-1:0] out;
    logic [CHANNELS-1:0] err;
    logic [CHANNELS-1:0] err_seen;

    modport master (
        output in, cfg_show, cfg_ondetect, err_clr,
        input  out, err, err_seen
    );

    modport slave (
        input  in, cfg_show, cfg_ondetect, err_clr,
        output out, err, err_seen
    );
endinterface

`default_nettype wire

// File: rtl/pulse_filter_chan.sv
`default_nettype none
// ============================================================================
//  Module   : pulse_filter_chan
//  Purpose  : One inertial pulse-filter path: DELAY-stage {value, tag} line,
//             saturating run counter, run classifier and error reporting.
//  Ports    : clk, rst_n      clock, asynchronous active-low reset
//             i_in            raw synchronised sample
//             i_show          1 = showcancelled (locked mode)
//             i_ondetect      1 = error on detect, 0 = error on event
//             i_err_clr       clears o_err_seen
//             o_out           filtered output (DELAY cycles latency)
//             o_err           cancelled-pulse indication
//             o_err_seen      sticky OR of o_err
//  Revision : 1.0  initial release
// ============================================================================

module pulse_filter_chan
    import pulse_filter_pkg::*;
#(
    parameter int DELAY      = 4,
    parameter int REJECT_LIM = 2,
    parameter int ERROR_LIM  = 3
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic i_in,
    input  wire logic i_show,
    input  wire logic i_ondetect,
    input  wire logic i_err_clr,
    output logic      o_out,
    output logic      o_err,
    output logic      o_err_seen
);

    `PULSE_FILTER_CHECK_PARAMS(DELAY, REJECT_LIM, ERROR_LIM)

    localparam int                 c_cnt_w  = cnt_w(ERROR_LIM);
    localparam logic [c_cnt_w-1:0] c_reject = c_cnt_w'(REJECT_LIM);
    localparam logic [c_cnt_w-1:0] c_error  = c_cnt_w'(ERROR_LIM);
    localparam logic [c_cnt_w-1:0] c_one    = c_cnt_w'(1);

    // Stage 0 always holds the most recent raw sample, so it doubles as the
    // "previous sample" for edge detection.
    logic [DELAY-1:0]   r_val_q, w_val_d;
    logic [DELAY-1:0]   r_tag_q, w_tag_d;
    logic [c_cnt_w-1:0] r_cnt_q, w_cnt_d;
    logic               r_det_q, w_det_d;
    logic               r_out_q, w_out_d;
    logic               r_err_q, w_err_d;
    logic               r_err_seen_q, w_err_seen_d;

    logic w_edge;
    logic w_short;
    logic w_report;
    logic w_fill;

    always_comb begin
        w_edge   = i_in ^ r_val_q[0];
        // Run width r_cnt_q is < ERROR_LIM <= DELAY whenever it is cancelled,
        // so the run occupies stages 0..cnt-1 and stage cnt is its predecessor.
        w_short  = w_edge && (r_cnt_q < c_error);
        w_report = w_short && (r_cnt_q >= c_reject) && i_show;

        w_fill = 1'b0;
        for (int k = 0; k < DELAY; k++) begin
            if (k == int'(r_cnt_q)) begin
                w_fill = r_val_q[k];
            end
        end

        // Default: plain shift. A cancelled run lands in stages 1..cnt after
        // the shift and is replaced by the (already filtered) predecessor.
        w_val_d    = r_val_q;
        w_tag_d    = r_tag_q;
        w_val_d[0] = i_in;
        w_tag_d[0] = 1'b0;
        for (int k = 1; k < DELAY; k++) begin
            if (w_short && (k <= int'(r_cnt_q))) begin
                w_val_d[k] = w_fill;
                w_tag_d[k] = w_report;
            end else begin
                w_val_d[k] = r_val_q[k-1];
                w_tag_d[k] = r_tag_q[k-1];
            end
        end

        if (w_edge) begin
            w_cnt_d = c_one;
        end else if (r_cnt_q == c_error) begin
            w_cnt_d = r_cnt_q;
        end else begin
            w_cnt_d = r_cnt_q + c_one;
        end

        w_det_d      = w_report;
        w_out_d      = r_val_q[DELAY-1];
        w_err_d      = i_ondetect ? r_det_q : r_tag_q[DELAY-1];
        // Set wins over clear when both happen in the same cycle.
        w_err_seen_d = r_err_q | (r_err_seen_q & ~i_err_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_val_q      <= '0;
            r_tag_q      <= '0;
            r_cnt_q      <= '0;
            r_det_q      <= 1'b0;
            r_out_q      <= 1'b0;
            r_err_q      <= 1'b0;
            r_err_seen_q <= 1'b0;
        end else begin
            r_val_q      <= w_val_d;
            r_tag_q      <= w_tag_d;
            r_cnt_q      <= w_cnt_d;
            r_det_q      <= w_det_d;
            r_out_q      <= w_out_d;
            r_err_q      <= w_err_d;
            r_err_seen_q <= w_err_seen_d;
        end
    end

    assign o_out      = r_out_q;
    assign o_err      = r_err_q;
    assign o_err_seen = r_err_seen_q;

endmodule

`default_nettype wire

// File: rtl/pulse_filter_array.sv
`default_nettype none
// ============================================================================
//  Module   : pulse_filter_array
//  Purpose  : CHANNELS independent inertial pulse filters with per-channel
//             showcancelled / on-detect reporting. Mode is captured once on
//             the first clock after reset and then held.
//  Ports    : clk             rising-edge clock
//             rst_n           asynchronous active-low reset
//             bus (slave)     in, cfg_show, cfg_ondetect, err_clr -> DUT
//                             out, err, err_seen                  <- DUT
//  Revision : 1.0  initial release
// ============================================================================

module pulse_filter_array
    import pulse_filter_pkg::*;
#(
    parameter int CHANNELS   = 4,
    parameter int DELAY      = 4,
    parameter int REJECT_LIM = 2,
    parameter int ERROR_LIM  = 3
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    pulse_filter_array_if.slave   bus
);

    `PULSE_FILTER_CHECK_PARAMS(DELAY, REJECT_LIM, ERROR_LIM)

    logic                       r_cfg_locked_q, w_cfg_locked_d;
    mode_t [CHANNELS-1:0]       r_mode_q, w_mode_d;

    logic [CHANNELS-1:0]        w_out;
    logic [CHANNELS-1:0]        w_err;
    logic [CHANNELS-1:0]        w_err_seen;

    // Mode registers load exactly once; afterwards they only hold.
    always_comb begin
        w_cfg_locked_d = 1'b1;
        w_mode_d       = r_mode_q;
        if (!r_cfg_locked_q) begin
            for (int i = 0; i < CHANNELS; i++) begin
                w_mode_d[i][SHOW]     = bus.cfg_show[i];
                w_mode_d[i][ONDETECT] = bus.cfg_ondetect[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cfg_locked_q <= 1'b0;
            r_mode_q       <= '0;
        end else begin
            r_cfg_locked_q <= w_cfg_locked_d;
            r_mode_q       <= w_mode_d;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        pulse_filter_chan #(
            .DELAY      (DELAY),
            .REJECT_LIM (REJECT_LIM),
            .ERROR_LIM  (ERROR_LIM)
        ) u_chan (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_in       (bus.in[g]),
            .i_show     (r_mode_q[g][SHOW]),
            .i_ondetect (r_mode_q[g][ONDETECT]),
            .i_err_clr  (bus.err_clr[g]),
            .o_out      (w_out[g]),
            .o_err      (w_err[g]),
            .o_err_seen (w_err_seen[g])
        );
    end

    assign bus.out      = w_out;
    assign bus.err      = w_err;
    assign bus.err_seen = w_err_seen;

endmodule

`default_nettype wire

// File: tb/tb_pulse_filter_array.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pulse_filter_array
//  Purpose  : Self-checking bench for pulse_filter_array (DELAY=4,
//             REJECT_LIM=2, ERROR_LIM=3). Directed scenarios with literal
//             per-edge expectations on ch0/ch1, plus a history-based model
//             of every channel compared on every cycle.
//  Revision : 1.0  initial release
// ============================================================================

module tb_pulse_filter_array;

    localparam int CHANNELS   = 4;
    localparam int DELAY      = 4;
    localparam int REJECT_LIM = 2;
    localparam int ERROR_LIM  = 3;
    localparam int NCYC       = 30;
    localparam int MAXT       = 256;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    int n_assert = 0;
    int n_fail   = 0;

    pulse_filter_array_if #(.CHANNELS(CHANNELS)) bus ();

    pulse_filter_array #(
        .CHANNELS   (CHANNELS),
        .DELAY      (DELAY),
        .REJECT_LIM (REJECT_LIM),
        .ERROR_LIM  (ERROR_LIM)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Model: keeps the whole sample history since reset, indexed by time.
    // On every raw edge the finished run is measured by looking back in
    // the history and, if short, its samples are rewritten with the sample
    // just before it. Expected out/err after edge t come from time t-DELAY.
    // ------------------------------------------------------------------
    int                  t = 0;
    logic                raw_h [CHANNELS][MAXT];
    logic                flt_h [CHANNELS][MAXT];
    logic                tag_h [CHANNELS][MAXT];
    logic [CHANNELS-1:0] m_show   = '0;
    logic [CHANNELS-1:0] m_ondet  = '0;
    logic [CHANNELS-1:0] det_pend = '0;
    logic [CHANNELS-1:0] exp_out  = '0;
    logic [CHANNELS-1:0] exp_err  = '0;
    logic [CHANNELS-1:0] exp_seen = '0;

    initial begin
        logic s, prev, fill, rep, o_n, e_n, sn;
        int   w;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                t        = 0;
                det_pend = '0;
                exp_out  = '0;
                exp_err  = '0;
                exp_seen = '0;
            end else if (t < MAXT) begin
                if (t == 0) begin
                    m_show  = bus.cfg_show;
                    m_ondet = bus.cfg_ondetect;
                end
                for (int c = 0; c < CHANNELS; c++) begin
                    s    = bus.in[c];
                    prev = (t > 0) ? raw_h[c][t-1] : 1'b0;
                    rep  = 1'b0;
                    if (s != prev) begin
                        w = 0;
                        while (w < ERROR_LIM && (t - 1 - w) >= 0 && raw_h[c][t-1-w] == prev)
                            w++;
                        if (w < ERROR_LIM) begin
                            fill = (t - w - 1 >= 0) ? flt_h[c][t-w-1] : 1'b0;
                            rep  = (w >= REJECT_LIM) && m_show[c];
                            for (int j = t - w; j < t; j++) begin
                                flt_h[c][j] = fill;
                                tag_h[c][j] = rep;
                            end
                        end
                    end
                    raw_h[c][t] = s;
                    flt_h[c][t] = s;
                    tag_h[c][t] = 1'b0;
                    sn  = exp_err[c] | (exp_seen[c] & ~bus.err_clr[c]);
                    o_n = (t >= DELAY) ? flt_h[c][t-DELAY] : 1'b0;
                    e_n = m_ondet[c] ? det_pend[c] : ((t >= DELAY) ? tag_h[c][t-DELAY] : 1'b0);
                    det_pend[c] = rep;
                    exp_out[c]  = o_n;
                    exp_err[c]  = e_n;
                    exp_seen[c] = sn;
                end
                t++;
            end
        end
    end

    task automatic cmpv(input string name, input logic [CHANNELS-1:0] act,
                        input logic [CHANNELS-1:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    // Compare process: mid-cycle, against the model.
    initial begin
        forever begin
            @(negedge clk);
            cmpv("model_out", bus.out, exp_out);
            cmpv("model_err", bus.err, exp_err);
            cmpv("model_err_seen", bus.err_seen, exp_seen);
        end
    end

    task automatic chk(input string name, input int e, input logic act, input logic exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s after edge %0d: got %b expected %b", name, e, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Directed scenarios. Edge 0 is the first clock after reset release.
    // Pulse [s, s+l) is high for edges s..s+l-1. Bit e of eo/ee/es is the
    // expected out/err/err_seen after edge e.
    // ------------------------------------------------------------------
    typedef struct {
        int          s0, l0, s0b, l0b, s1, l1;
        bit          alt;
        logic [3:0]  show, ondet;
        int          tog, rst_at, clr0, clr1;
        logic [31:0] eo0, ee0, es0, eo1, ee1, es1;
    } scen_t;

    scen_t sc [9];

    task automatic run_scen(input int idx, input scen_t s);
        logic [CHANNELS-1:0] v;
        rst_n            = 1'b0;
        bus.in           = '0;
        bus.err_clr      = '0;
        bus.cfg_show     = s.show;
        bus.cfg_ondetect = s.ondet;
        repeat (2) @(posedge clk);
        #2;
        chk($sformatf("s%0d_rst_out", idx), -1, |bus.out, 1'b0);
        chk($sformatf("s%0d_rst_err", idx), -1, |bus.err, 1'b0);
        chk($sformatf("s%0d_rst_seen", idx), -1, |bus.err_seen, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int e = 0; e < NCYC; e++) begin
            v[0] = (e >= s.s0 && e < s.s0 + s.l0) ||
                   (e >= s.s0b && e < s.s0b + s.l0b) ||
                   (s.alt && e >= 10 && e < 20 && (e % 2) == 0);
            v[1] = (e >= s.s1 && e < s.s1 + s.l1);
            v[2] = (((e >> 1) & 1) != ((e >> 3) & 1));
            v[3] = ((e % 5) == 0) || ((e % 7) == 3);
            bus.in      = v;
            bus.err_clr = (e == s.clr0 || e == s.clr1) ? 4'b0001 : 4'b0000;
            if (e == s.tog) bus.cfg_show = ~s.show;
            if (e == s.rst_at) begin
                rst_n            = 1'b0;
                bus.cfg_ondetect = 4'hF;
            end
            if (e == s.rst_at + 2) rst_n = 1'b1;
            @(posedge clk);
            #2;
            chk($sformatf("s%0d_ch0_out", idx), e, bus.out[0], s.eo0[e]);
            chk($sformatf("s%0d_ch0_err", idx), e, bus.err[0], s.ee0[e]);
            chk($sformatf("s%0d_ch0_seen", idx), e, bus.err_seen[0], s.es0[e]);
            chk($sformatf("s%0d_ch1_out", idx), e, bus.out[1], s.eo1[e]);
            chk($sformatf("s%0d_ch1_err", idx), e, bus.err[1], s.ee1[e]);
            chk($sformatf("s%0d_ch1_seen", idx), e, bus.err_seen[1], s.es1[e]);
        end
    endtask

    initial begin
        //          s0  l0   s0b l0b s1  l1 alt show  ondet  tog rst clr0 clr1  eo0           ee0           es0           eo1  ee1           es1
        // step held from edge 10
        sc[0] = '{10, 100, 0,  0,  0,  0, 0, 4'hF, 4'h0, -1, 100, -1, -1, 32'h3FFFC000, 32'h0,        32'h0,        32'h0, 32'h0,        32'h0};
        // 1-cycle pulse, removed silently
        sc[1] = '{10, 1,   0,  0,  0,  0, 0, 4'hF, 4'h0, -1, 100, -1, -1, 32'h0,        32'h0,        32'h0,        32'h0, 32'h0,        32'h0};
        // 2-cycle pulse, on-event; clear collides with err at 15, clean clear at 20
        sc[2] = '{10, 2,   0,  0,  0,  0, 0, 4'hF, 4'h0, -1, 100, 15, 20, 32'h0,        32'h0000C000, 32'h000F8000, 32'h0, 32'h0,        32'h0};
        // 2-cycle pulse, on-detect
        sc[3] = '{10, 2,   0,  0,  0,  0, 0, 4'hF, 4'hF, -1, 100, -1, -1, 32'h0,        32'h00002000, 32'h3FFFC000, 32'h0, 32'h0,        32'h0};
        // 2-cycle pulse, noshowcancelled
        sc[4] = '{10, 2,   0,  0,  0,  0, 0, 4'h0, 4'h0, -1, 100, -1, -1, 32'h0,        32'h0,        32'h0,        32'h0, 32'h0,        32'h0};
        // 3-cycle pulse on ch0 passes, 2-cycle pulse on ch1 flagged
        sc[5] = '{10, 3,   0,  0, 10,  2, 0, 4'hF, 4'h0, -1, 100, -1, -1, 32'h0001C000, 32'h0,        32'h0,        32'h0, 32'h0000C000, 32'h3FFF8000};
        // alternating 1-cycle pattern, edges 10..19
        sc[6] = '{0,  0,   0,  0,  0,  0, 1, 4'hF, 4'h0, -1, 100, -1, -1, 32'h0,        32'h0,        32'h0,        32'h0, 32'h0,        32'h0};
        // cfg_show flipped at edge 20 after lock, pulse at 22-23
        sc[7] = '{22, 2,   0,  0,  0,  0, 0, 4'hF, 4'h0, 20, 100, -1, -1, 32'h0,        32'h0C000000, 32'h38000000, 32'h0, 32'h0,        32'h0};
        // reset at edge 12 cuts pulse 10-11; on-detect captured after release
        sc[8] = '{10, 2,  20,  2,  0,  0, 0, 4'hF, 4'h0, -1,  12, -1, -1, 32'h0,        32'h00800000, 32'h3F000000, 32'h0, 32'h0,        32'h0};

        bus.in           = '0;
        bus.err_clr      = '0;
        bus.cfg_show     = '0;
        bus.cfg_ondetect = '0;
        #1;
        rst_n = 1'b0;
        for (int i = 0; i < 9; i++) begin
            run_scen(i, sc[i]);
        end
        repeat (2) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pulse_filter_array.md
# pulse_filter_array

Multi-channel, cycle-based inertial pulse filter with configurable cancelled-pulse reporting. It is the synthesizable successor to single-path specify-block pulse control, generalised to `CHANNELS` independent paths, parametrised delay, and reject and error limits, and it adds showcancelled / on-detect reporting per channel. It sits between asynchronous-ish stimulus sources, already synchronised to `clk`, and downstream logic that must not see glitches.

## Interface
- `CHANNELS`, default 4: number of independent paths.
- `DELAY`, default 4: path delay in cycles. Must be ≥ 1.
- `REJECT_LIM`, default 2: runs shorter than this are removed silently. Must be ≥ 1.
- `ERROR_LIM`, default 3: runs in [REJECT_LIM, ERROR_LIM) are error pulses. Requires REJECT_LIM ≤ ERROR_LIM ≤ DELAY; violation is an elaboration error.
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `in`, input, CHANNELS: raw path inputs, sampled each rising edge.
- `cfg_show`, input, CHANNELS: 1 = showcancelled for the channel; 0 = noshowcancelled.
- `cfg_ondetect`, input, CHANNELS: 1 = report error on detection; 0 = report error on event.
- `out`, output, CHANNELS: filtered, delayed outputs.
- `err`, output, CHANNELS: cancelled-pulse indication.
- `err_seen`, output, CHANNELS: sticky OR of `err`.
- `err_clr`, input, CHANNELS: clears `err_seen` for the channel.

## Operation
- **Reset state.** Reset asserted gives `out`=0, `err`=0, `err_seen`=0, delay lines all 0, run counters 0 and `cfg_locked`=0.
- **Config lock.** On the first clock after `rst_n` deasserts, `cfg_show` and `cfg_ondetect` are captured and `cfg_locked` is set. Later changes are ignored until the next reset. A pulse-control mode cannot change once a path is in use.
- **Delay line.** Each channel has a `DELAY`-stage shift line of {value, tag}. A sample taken at edge n appears on `out` after edge n+DELAY unless it is modified.
- **Run counter.** Each channel has a run counter that counts consecutive identical raw samples and saturates at ERROR_LIM. A raw edge (sample ≠ previous sample) terminates the current run with width w.
- **Run classification.** The run is classified at the terminating edge. Only runs bounded by edges on both sides are classified; the first run after reset counts as bounded.
  - w < REJECT_LIM: all w delay-line entries of the run are overwritten with the value of the entry preceding the run, tag=0.
  - REJECT_LIM ≤ w < ERROR_LIM: the entries are overwritten the same way. If `cfg_show`=1, tag=1; otherwise tag=0 (the pulse is dropped silently, as noshowcancelled).
  - w ≥ ERROR_LIM: the run passes unchanged.
- **Lookahead guarantee.** Because ERROR_LIM ≤ DELAY, every run being classified is still entirely inside the line.
- **Error reporting, on-event (`cfg_ondetect`=0).** `err` = tag of the output stage. `err` is high for w cycles, aligned to when the pulse would have appeared on `out`.
- **Error reporting, on-detect (`cfg_ondetect`=1).** Tags are not used. `err` pulses for 1 cycle on the edge after the terminating edge is sampled.
- **Sticky flag.** `err_seen` is set by `err`. If `err_clr` and `err` are high in the same cycle, set wins.
- **Channel independence.** Channels never interact.

## Timing
- Path latency is exactly DELAY cycles for accepted transitions.
- On-detect `err` latency is 1 cycle after the terminating raw edge. On-event `err` latency is DELAY cycles after the pulse's leading edge.
- Back-to-back short runs: each run is neutralised against the already-filtered preceding entry. An alternating 1-cycle pattern therefore yields constant `out`.
- Reset mid-operation clears all pending entries immediately (asynchronous). No `err` is produced for a run cut by reset.
- `out` and `err` are registered outputs with no combinational path from `in`.

## Structure
- Package `pulse_filter_pkg` holds:
  - the `mode` encoding constants (`SHOW`, `ONDETECT`);
  - `cnt_w(ERROR_LIM)` as a `$clog2`-based function;
  - the parameter-legality check macro.
- Sub-module `pulse_filter_chan` implements one channel: delay line, run counter, classifier and error logic. The top level generates `CHANNELS` instances plus the shared `cfg_locked` register.

## Test plan
All scenarios use DELAY=4, REJECT_LIM=2, ERROR_LIM=3 and ch0 unless stated otherwise.
- Reset → `out`=0, `err`=0 and `err_seen`=0 while `rst_n`=0; the same values hold 1 cycle after release with `in`=0.
- Step: `in` goes to 1 at edge 10 and is held → `out` rises after edge 14; `err` stays 0.
- 1-cycle pulse (edge 10 high, edge 11 low), `cfg_show`=1 → `out` stays 0 and `err` stays 0.
- 2-cycle pulse (edges 10–11), `cfg_show`=1:
  - on-event → `err`=1 after edges 14 and 15, `out`=0 throughout;
  - on-detect → `err`=1 only after edge 13;
  - `cfg_show`=0 → `err` never asserts.
- 3-cycle pulse (edges 10–12) → `out`=1 after edges 14–16, `err`=0. A simultaneous 2-cycle pulse on ch1 flags only ch1.
- `cfg_show` toggled at edge 20 after lock → behaviour unchanged. `rst_n` pulsed low at edge 12 during a pending pulse → `out`/`err` are 0 with no late `err`, and the new config is captured after release.
